line_buf_ctrl_1bit: RTL and testbench
=====================================

LINE_BUF_CTRL_1BIT -- requirements
Module: line_buf_ctrl_1bit

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line; legal range 3..2048.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame; legal range 3..4095.
REQ-003 clk  input  1  single clock; both line FIFOs run on it, with wr_clk = rd_clk = clk.
REQ-004 rst  input  1  reset, asynchronous, active-high; also drives both FIFO wr_rst/rd_rst.
REQ-005 sof  input  1  start-of-frame pulse, one cycle, precedes the first pixel.
REQ-006 pix_vld / pix_data  input  1 / 1  incoming binary pixel, raster order.
REQ-007 f0_wr_en, f0_wr_data, f0_rd_en  output  1 each  control of line FIFO 0 (newest stored line).
REQ-008 f0_rd_data, f0_empty, f0_full  input  1 each  status and data from FIFO 0.
REQ-009 f1_wr_en, f1_wr_data, f1_rd_en  output  1 each; f1_rd_data, f1_empty, f1_full  input  1 each  same for FIFO 1 (older line).
REQ-010 tap_vld  output  1  3-row column tap valid.
REQ-011 tap_r0 / tap_r1 / tap_r2  output  1 each  pixel of line n-2 / n-1 / n at the same column.
REQ-012 tap_col  output  11  column of the current tap.
REQ-013 tap_row  output  12  line index n of the current tap.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 err  output  1  sticky error flag.

Function
REQ-016 The block SHALL treat the FIFO read latency as 1 cycle: f*_rd_data is valid the cycle after f*_rd_en.
REQ-017 The block SHALL implement states IDLE, FILL0, FILL1, RUN and DRAIN.
REQ-018 IDLE: sof -> FILL0; pix_vld is ignored in IDLE.
REQ-019 FILL0 (line 0): each pix_vld writes pix_data into FIFO 0; no reads; no taps.
REQ-020 FILL1 (line 1): each pix_vld reads FIFO 0 and writes pix_data into FIFO 0; one cycle later, f0_rd_data is written into FIFO 1; no taps.
REQ-021 RUN (lines 2..IMG_HEIGHT-1): each pix_vld reads FIFO 0 and FIFO 1 and writes pix_data into FIFO 0.
REQ-022 RUN, one cycle after each pix_vld: f0_rd_data is written into FIFO 1 and tap_vld = 1.
REQ-023 RUN tap outputs SHALL be: tap_r2 = pix_data delayed 1 cycle, tap_r1 = f0_rd_data, tap_r0 = f1_rd_data.
REQ-024 Pixel-to-tap latency SHALL be exactly 1 cycle; tap_col and tap_row SHALL be those of the originating pixel.
REQ-025 The column counter SHALL increment per pix_vld and wrap IMG_WIDTH-1 -> 0; on wrap the line counter increments.
REQ-026 State advance on column wrap: FILL0 -> FILL1 -> RUN.
REQ-027 At the last pixel of line IMG_HEIGHT-1 the block SHALL go from RUN to DRAIN.
REQ-028 DRAIN SHALL assert f*_rd_en each cycle while the corresponding f*_empty is 0, with no writes and no taps.
REQ-029 DRAIN -> IDLE when both FIFOs are empty, or -> FILL0 if sof is pending.
REQ-030 sof in DRAIN SHALL be latched as pending; sof in FILL0/FILL1/RUN SHALL abort to DRAIN with the latch set and err set.
REQ-031 A required write with f*_full = 1 SHALL be suppressed and set err.
REQ-032 A required read with f*_empty = 1 SHALL be suppressed, set err, and force tap_vld low for that pixel.
REQ-033 sof and pix_vld in the same cycle: sof takes priority and pix_vld is dropped.
REQ-034 FIFO enables SHALL never be asserted in IDLE.

Reset
REQ-035 On rst the block SHALL enter IDLE and clear the counters, the pending latch and err.
REQ-036 During rst all outputs SHALL be 0.
REQ-037 A mid-frame rst SHALL also reset the FIFOs through the shared reset; no DRAIN is needed afterwards.

Structure
REQ-038 A shared package SHALL hold the state enumeration, COL_W = 11, ROW_W = 12 and the FIFO read latency constant (1).
REQ-039 The RTL SHALL be one module; the two fifo_line_buffer_1bit instances are placed by the parent, not inside this block.

Verification
REQ-040 W=8, H=4, all-ones frame -> 16 tap_vld pulses, all taps = 1, each 1 cycle after its pixel; busy drops after DRAIN; err = 0.
REQ-041 Pixel value = row parity, W=8, H=5 -> every tap has r0/r1/r2 = alternating parity of rows n-2/n-1/n; tap_row runs 2..4.
REQ-042 pix_vld gaps of random length 0..3 cycles -> identical tap sequence to the gapless run; FIFOs empty at IDLE.
REQ-043 sof at row 3 column 2 of an H=6 frame -> err = 1, DRAIN empties both FIFOs, new frame starts FILL0; first tap at row 2 of the new frame.
REQ-044 Model with f0_full forced to 1 for one write -> write suppressed, err = 1; rst clears err and returns busy = 0 within 1 cycle.
REQ-045 Back-to-back frames with sof during DRAIN -> pending latch set; second frame taps bit-exact with the reference model.

Source files
------------

// File: rtl/line_buf_ctrl_1bit_pkg.sv
// Shared types and constants for the 1-bit three-row line buffer controller.
package line_buf_ctrl_1bit_pkg;

    localparam int unsigned COL_W       = 11;
    localparam int unsigned ROW_W       = 12;
    localparam int unsigned FIFO_RD_LAT = 1;

    typedef enum logic [2:0] {
        StIdle,
        StFill0,
        StFill1,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/line_buf_ctrl_1bit.sv
// Controller for two external 1-bit line FIFOs producing a 3-row column tap
// (rows n-2, n-1, n) for binary raster images.
module line_buf_ctrl_1bit
    import line_buf_ctrl_1bit_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             pix_vld,
    input  logic             pix_data,
    output logic             f0_wr_en,
    output logic             f0_wr_data,
    output logic             f0_rd_en,
    input  logic             f0_rd_data,
    input  logic             f0_empty,
    input  logic             f0_full,
    output logic             f1_wr_en,
    output logic             f1_wr_data,
    output logic             f1_rd_en,
    input  logic             f1_rd_data,
    input  logic             f1_empty,
    input  logic             f1_full,
    output logic             tap_vld,
    output logic             tap_r0,
    output logic             tap_r1,
    output logic             tap_r2,
    output logic [COL_W-1:0] tap_col,
    output logic [ROW_W-1:0] tap_row,
    output logic             busy,
    output logic             err
);

    if (IMG_WIDTH < 3 || IMG_WIDTH > 2048 || IMG_HEIGHT < 3 || IMG_HEIGHT > 4095 ||
        FIFO_RD_LAT != 1) begin : g_param_check
        $error("line_buf_ctrl_1bit: unsupported parameterisation");
    end

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;

    // Stage 1: one entry per pixel that issued FIFO reads, resolved when rd_data lands.
    logic             s1_vld_q, s1_vld_d;
    logic             s1_run_q, s1_run_d;
    logic             s1_f0_ok_q, s1_f0_ok_d;
    logic             s1_ok_q, s1_ok_d;
    logic             s1_pix_q;
    logic [COL_W-1:0] s1_col_q;
    logic [ROW_W-1:0] s1_row_q;

    logic in_frame, accept, col_last, row_last, line_end, abort;
    logic need_wr0, need_rd0, need_rd1, need_wr1, drain;

    assign in_frame = (state_q == StFill0) || (state_q == StFill1) || (state_q == StRun);
    assign accept   = in_frame && pix_vld && !sof;
    assign abort    = in_frame && sof;
    assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign line_end = accept && col_last;
    assign drain    = (state_q == StDrain);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            StIdle: begin
                if (sof) state_d = StFill0;
            end
            StFill0, StFill1, StRun: begin
                if (abort) begin
                    state_d = StDrain;
                    pend_d  = 1'b1;
                end else if (line_end) begin
                    if (state_q == StFill0)      state_d = StFill1;
                    else if (state_q == StFill1) state_d = StRun;
                    else if (row_last)           state_d = StDrain;
                end
            end
            StDrain: begin
                if (sof) pend_d = 1'b1;
                // Wait for the last pixel's deferred FIFO 1 write before declaring empty.
                if (f0_empty && f1_empty && !s1_vld_q) begin
                    pend_d  = 1'b0;
                    state_d = (sof || pend_q) ? StFill0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        need_wr0   = accept;
        need_rd0   = accept && (state_q == StFill1 || state_q == StRun);
        need_rd1   = accept && (state_q == StRun);
        need_wr1   = s1_vld_q && s1_f0_ok_q;

        f0_wr_en   = need_wr0 && !f0_full;
        f0_wr_data = f0_wr_en && pix_data;
        f0_rd_en   = (need_rd0 || drain) && !f0_empty;
        f1_rd_en   = (need_rd1 || drain) && !f1_empty;
        f1_wr_en   = need_wr1 && !f1_full;
        f1_wr_data = f1_wr_en && f0_rd_data;

        tap_vld    = s1_vld_q && s1_run_q && s1_ok_q;
        tap_r0     = tap_vld && f1_rd_data;
        tap_r1     = tap_vld && f0_rd_data;
        tap_r2     = tap_vld && s1_pix_q;
        tap_col    = s1_col_q;
        tap_row    = s1_row_q;

        busy       = (state_q != StIdle);
        err        = err_q;
        err_d      = err_q || abort ||
                     (need_wr0 && f0_full) || (need_wr1 && f1_full) ||
                     (need_rd0 && f0_empty) || (need_rd1 && f1_empty);
    end

    // Counters and stage-1 next state
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        s1_vld_d   = need_rd0;
        s1_run_d   = (state_q == StRun);
        s1_f0_ok_d = !f0_empty;
        s1_ok_d    = !f0_empty && (!f1_empty || state_q != StRun);
        if (state_d == StFill0 && state_q != StFill0) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_run_q   <= 1'b0;
            s1_f0_ok_q <= 1'b0;
            s1_ok_q    <= 1'b0;
            s1_pix_q   <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            s1_vld_q   <= s1_vld_d;
            s1_run_q   <= s1_run_d;
            s1_f0_ok_q <= s1_f0_ok_d;
            s1_ok_q    <= s1_ok_d;
            if (accept) begin
                s1_pix_q <= pix_data;
                s1_col_q <= col_q;
                s1_row_q <= row_q;
            end
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl_1bit.sv
// Directed bench: behavioural line FIFOs, per-pixel tap expectations, control-path checks.
module tb_line_buf_ctrl_1bit;

    localparam int W     = 8;
    localparam int H     = 5;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sof = 1'b0, pix_vld = 1'b0, pix_data = 1'b0;
    logic force0 = 1'b0;
    logic f0_wr_en, f0_wr_data, f0_rd_en, f0_rd_data, f0_empty, f0_full;
    logic f1_wr_en, f1_wr_data, f1_rd_en, f1_rd_data, f1_empty, f1_full;
    logic tap_vld, tap_r0, tap_r1, tap_r2, busy, err;
    logic [10:0] tap_col;
    logic [11:0] tap_row;

    typedef struct {
        logic [25:0] key;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   q0[$];
    bit   q1[$];
    int   cnt0 = 0, cnt1 = 0;
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0, tap_seen = 0;

    line_buf_ctrl_1bit #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_vld    (pix_vld),
        .pix_data   (pix_data),
        .f0_wr_en   (f0_wr_en),
        .f0_wr_data (f0_wr_data),
        .f0_rd_en   (f0_rd_en),
        .f0_rd_data (f0_rd_data),
        .f0_empty   (f0_empty),
        .f0_full    (f0_full),
        .f1_wr_en   (f1_wr_en),
        .f1_wr_data (f1_wr_data),
        .f1_rd_en   (f1_rd_en),
        .f1_rd_data (f1_rd_data),
        .f1_empty   (f1_empty),
        .f1_full    (f1_full),
        .tap_vld    (tap_vld),
        .tap_r0     (tap_r0),
        .tap_r1     (tap_r1),
        .tap_r2     (tap_r2),
        .tap_col    (tap_col),
        .tap_row    (tap_row),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFOs, one-cycle read latency, flags from registered counts
    assign f0_empty = (cnt0 == 0);
    assign f1_empty = (cnt1 == 0);
    assign f0_full  = (cnt0 >= DEPTH) || force0;
    assign f1_full  = (cnt1 >= DEPTH);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            cnt0       <= 0;
            f0_rd_data <= 1'b0;
        end else begin
            if (f0_rd_en && q0.size() > 0) f0_rd_data <= q0.pop_front();
            if (f0_wr_en && q0.size() < DEPTH) q0.push_back(f0_wr_data);
            cnt0 <= q0.size();
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            cnt1       <= 0;
            f1_rd_data <= 1'b0;
        end else begin
            if (f1_rd_en && q1.size() > 0) f1_rd_data <= q1.pop_front();
            if (f1_wr_en && q1.size() < DEPTH) q1.push_back(f1_wr_data);
            cnt1 <= q1.size();
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pix_of(input int pat, input int r, input int c);
        case (pat)
            0:       return 1'b1;
            1:       return (r % 2) == 1;
            2:       return ((r + c) % 2) == 1;
            default: return ((r * 3 + c * 5) % 7) < 3;
        endcase
    endfunction

    function automatic logic [25:0] tap_key(input int pat, input int r, input int c);
        return {12'(r), 11'(c), pix_of(pat, r - 2, c), pix_of(pat, r - 1, c), pix_of(pat, r, c)};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && tap_vld) begin
            tap_seen++;
            if (exp_q.size() == 0) begin
                check("tap_extra", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("tap", {6'd0, tap_row, tap_col, tap_r0, tap_r1, tap_r2}, {6'd0, e.key});
                check("tap_lat", cyc, e.cyc);
            end
        end
    end

    // Abort at (ab_r, ab_c) replaces that pixel with a sof; use -1 for a full frame.
    task automatic drive_frame(input int pat, input bit with_sof, input bit gaps,
                               input int ab_r, input int ab_c);
        exp_t e;
        @(posedge clk); #1;
        if (with_sof) begin
            sof = 1'b1; pix_vld = 1'b1; pix_data = 1'b1;
            @(posedge clk); #1;
            sof = 1'b0; pix_vld = 1'b0;
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if (r == ab_r && c == ab_c) begin
                    sof = 1'b1;
                    @(posedge clk); #1;
                    sof = 1'b0;
                    return;
                end
                pix_vld  = 1'b1;
                pix_data = pix_of(pat, r, c);
                if (r >= 2) begin
                    e.key = tap_key(pat, r, c);
                    e.cyc = cyc + 1;
                    exp_q.push_back(e);
                end
                @(posedge clk); #1;
                pix_vld = 1'b0;
            end
        end
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (cnt0 == 0 && cnt1 == 0) break;
            n++;
        end
        check({tag, "_drain_to"}, 32'(n < 100), 32'd1);
    endtask

    task automatic finish_frame(input string tag, input int n_taps, input logic exp_err);
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_ntaps"}, tap_seen, n_taps);
        check({tag, "_left"}, exp_q.size(), 32'd0);
        check({tag, "_fifo"}, cnt0 + cnt1, 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        tap_seen = 0;
    endtask

    initial begin
        #1;
        check("rst_ctl", {20'd0, f0_wr_en, f0_wr_data, f0_rd_en, f1_wr_en, f1_wr_data, f1_rd_en,
                          tap_vld, tap_r0, tap_r1, tap_r2, busy, err}, 32'd0);
        check("rst_pos", {9'd0, tap_col, tap_row}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        drive_frame(0, 1'b1, 1'b0, -1, -1);
        finish_frame("ones", (H - 2) * W, 1'b0);
        drive_frame(1, 1'b1, 1'b0, -1, -1);
        finish_frame("parity", (H - 2) * W, 1'b0);
        drive_frame(1, 1'b1, 1'b1, -1, -1);
        finish_frame("parity_gap", (H - 2) * W, 1'b0);

        // Back-to-back: sof lands in DRAIN and is held pending
        drive_frame(3, 1'b1, 1'b0, -1, -1);
        sof = 1'b1; pix_vld = 1'b1;
        @(posedge clk); #1;
        sof = 1'b0; pix_vld = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_drained("b2b");
        drive_frame(2, 1'b0, 1'b1, -1, -1);
        finish_frame("b2b", 2 * (H - 2) * W, 1'b0);

        // Abort at row 3 column 2: taps for row 2 and (3,0),(3,1) still emerge
        drive_frame(2, 1'b1, 1'b0, 3, 2);
        check("abort_err", 32'(err), 32'd1);
        wait_drained("abort");
        drive_frame(3, 1'b0, 1'b0, -1, -1);
        finish_frame("abort", W + 2 + (H - 2) * W, 1'b1);

        @(negedge clk); rst = 1'b1; #1;
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Forced-full write on the first pixel
        @(posedge clk); #1; sof = 1'b1;
        @(posedge clk); #1; sof = 1'b0;
        pix_vld = 1'b1; pix_data = 1'b1; force0 = 1'b1;
        #1;
        check("full_wr_en", 32'(f0_wr_en), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        pix_vld = 1'b0; force0 = 1'b0;
        check("full_err", 32'(err), 32'd1);
        check("full_cnt", cnt0, 32'd0);
        rst = 1'b1; #1;
        check("full_rst", {30'd0, busy, err}, 32'd0);
        @(negedge clk); rst = 1'b0;

        drive_frame(3, 1'b1, 1'b1, -1, -1);
        finish_frame("post_rst", (H - 2) * W, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
